// File: rtl/fm_pkg.sv
// Shared types for the FM hop scheduler: default widths, hop-table entry layout, FSM states.
package fm_pkg;

    localparam int FM_PW      = 24;
    localparam int FM_NENT    = 8;
    localparam int FM_AW      = 3;
    localparam int FM_DWELL_W = 16;

    typedef struct packed {
        logic signed [FM_PW-1:0] carr;
        logic signed [FM_PW-1:0] shift;
        logic [FM_DWELL_W-1:0]   dwell;
    } hop_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } hop_state_t;

endpackage

// File: rtl/fm_hop_table.sv
// Hop table register file: one synchronous write port, one asynchronous read port.
module fm_hop_table
    import fm_pkg::*;
#(
    parameter int NENT = FM_NENT,
    parameter int AW   = FM_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  hop_entry_t      i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output hop_entry_t      o_rdata
);

    hop_entry_t r_mem [NENT];

    // Reset clears every entry so a sequence started straight after reset drives zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fm_hop_ctrl.sv
// Frequency-hopping scheduler: steps through the hop table, holding each entry for its dwell,
// and is the sole driver of the modulator's carrier FCW, deviation FCW and enable.
module fm_hop_ctrl
    import fm_pkg::*;
#(
    parameter int PW      = FM_PW,
    parameter int NENT    = FM_NENT,
    parameter int AW      = FM_AW,
    parameter int DWELL_W = FM_DWELL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [PW-1:0] cfg_carr,
    input  logic signed [PW-1:0] cfg_shift,
    input  logic [DWELL_W-1:0]   cfg_dwell,
    output logic                 cfg_err,
    input  logic [AW-1:0]        last_idx,
    input  logic                 loop,
    input  logic                 start,
    input  logic                 stop,
    output logic signed [PW-1:0] carr_freq,
    output logic signed [PW-1:0] freq_shift,
    output logic                 mod_en,
    output logic                 busy,
    output logic                 hop_stb,
    output logic [AW-1:0]        cur_idx,
    output logic                 done
);

    hop_state_t             r_state;
    hop_state_t             w_state_nxt;
    logic [AW-1:0]          r_idx;
    logic [AW-1:0]          r_last_idx;
    logic                   r_loop;
    logic [DWELL_W-1:0]     r_cnt;
    logic [DWELL_W-1:0]     r_dwell;
    logic signed [PW-1:0]   r_carr;
    logic signed [PW-1:0]   r_shift;
    logic [AW-1:0]          r_cur_idx;
    logic                   r_hop_stb;
    logic                   r_cfg_err;
    logic                   w_tbl_we;
    logic                   w_dwell_end;
    logic                   w_more;
    logic                   w_active;
    hop_entry_t             w_wdata;
    hop_entry_t             w_rd;

    assign w_active    = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign w_tbl_we    = cfg_we && !w_active;
    assign w_wdata     = '{carr: cfg_carr, shift: cfg_shift, dwell: cfg_dwell};
    assign w_dwell_end = (r_cnt == r_dwell - DWELL_W'(1));
    assign w_more      = (r_idx < r_last_idx) || r_loop;

    fm_hop_table #(
        .NENT (NENT),
        .AW   (AW)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_tbl_we),
        .i_waddr (cfg_addr),
        .i_wdata (w_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mod_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mod_en      = 1'b1;
                busy        = 1'b1;
                w_state_nxt = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                mod_en = 1'b1;
                busy   = 1'b1;
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dwell_end) begin
                    w_state_nxt = w_more ? ST_LOAD : ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The LOAD cycle keeps the previous entry on the outputs, so the new one appears
    // together with hop_stb and the carrier never gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_last_idx <= '0;
            r_loop     <= 1'b0;
            r_cnt      <= '0;
            r_dwell    <= '0;
            r_carr     <= '0;
            r_shift    <= '0;
            r_cur_idx  <= '0;
            r_hop_stb  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_hop_stb <= 1'b0;
            r_cfg_err <= cfg_we && w_active;
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_last_idx <= last_idx;
                        r_loop     <= loop;
                        r_idx      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (!stop) begin
                        r_carr    <= w_rd.carr;
                        r_shift   <= w_rd.shift;
                        r_dwell   <= (w_rd.dwell == '0) ? DWELL_W'(1) : w_rd.dwell;
                        r_cur_idx <= r_idx;
                        r_cnt     <= '0;
                        r_hop_stb <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stop) begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                        if (w_dwell_end) begin
                            r_idx <= (r_idx < r_last_idx) ? r_idx + AW'(1) : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign carr_freq  = r_carr;
    assign freq_shift = r_shift;
    assign cur_idx    = r_cur_idx;
    assign hop_stb    = r_hop_stb;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_fm_hop_ctrl.sv
// Directed bench for fm_hop_ctrl: cycle-accurate control checks plus a hop scoreboard.
module tb_fm_hop_ctrl;

    localparam int PW      = 24;
    localparam int AW      = 3;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [PW-1:0]      cfg_carr;
    logic [PW-1:0]      cfg_shift;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_err;
    logic [AW-1:0]      last_idx;
    logic               loop;
    logic               start;
    logic               stop;
    logic [PW-1:0]      carr_freq;
    logic [PW-1:0]      freq_shift;
    logic               mod_en;
    logic               busy;
    logic               hop_stb;
    logic [AW-1:0]      cur_idx;
    logic               done;

    typedef struct {
        logic [PW-1:0] carr;
        logic [PW-1:0] shift;
        logic [AW-1:0] idx;
    } hop_exp_t;

    hop_exp_t sb_q[$];
    int total = 0;
    int bad   = 0;

    fm_hop_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_carr   (cfg_carr),
        .cfg_shift  (cfg_shift),
        .cfg_dwell  (cfg_dwell),
        .cfg_err    (cfg_err),
        .last_idx   (last_idx),
        .loop       (loop),
        .start      (start),
        .stop       (stop),
        .carr_freq  (carr_freq),
        .freq_shift (freq_shift),
        .mod_en     (mod_en),
        .busy       (busy),
        .hop_stb    (hop_stb),
        .cur_idx    (cur_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("tag=%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [PW-1:0] c, input logic [PW-1:0] s, input logic [AW-1:0] i);
        hop_exp_t e;
        e.carr  = c;
        e.shift = s;
        e.idx   = i;
        sb_q.push_back(e);
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [PW-1:0] c,
                               input logic [PW-1:0] s, input logic [DWELL_W-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_carr  = c;
        cfg_shift = s;
        cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Runs one sequence from the current cycle (cycle 0 = start high) and checks the
    // per-cycle control outputs against bit masks indexed by cycle number.
    task automatic run_seq(input string name, input int ncyc, input int stop_cyc,
                           input logic [31:0] hop_m, input logic [31:0] done_m,
                           input logic [31:0] en_m);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            start = 1'b0;
            stop  = 1'b0;
            check($sformatf("%s hop_stb c%0d", name, c), 64'(hop_stb), 64'(hop_m[c]));
            check($sformatf("%s done c%0d", name, c), 64'(done), 64'(done_m[c]));
            check($sformatf("%s mod_en c%0d", name, c), 64'(mod_en), 64'(en_m[c]));
            check($sformatf("%s busy c%0d", name, c), 64'(busy), 64'(en_m[c]));
            if (c == stop_cyc) stop = 1'b1;
        end
    endtask

    // Scoreboard: every hop strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && hop_stb) begin
            if (sb_q.size() == 0) begin
                check("sb unexpected hop_stb", 64'(1), 64'(0));
            end else begin
                hop_exp_t e;
                e = sb_q.pop_front();
                check("sb carr_freq", 64'(carr_freq), 64'(e.carr));
                check("sb freq_shift", 64'(freq_shift), 64'(e.shift));
                check("sb cur_idx", 64'(cur_idx), 64'(e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_carr = '0; cfg_shift = '0;
        cfg_dwell = '0; last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
        tick();
        check("rst carr_freq", 64'(carr_freq), 64'(0));
        check("rst freq_shift", 64'(freq_shift), 64'(0));
        check("rst mod_en", 64'(mod_en), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst hop_stb", 64'(hop_stb), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst cur_idx", 64'(cur_idx), 64'(0));
        check("rst cfg_err", 64'(cfg_err), 64'(0));
        rst = 1'b0;
        tick();

        // Two-entry sequence, no loop
        write_entry(3'd0, 24'h100000, 24'h010000, 16'd3);
        write_entry(3'd1, 24'h200000, 24'h020000, 16'd2);
        check("idle write cfg_err", 64'(cfg_err), 64'(0));
        last_idx = 3'd1;
        loop     = 1'b0;
        push_exp(24'h100000, 24'h010000, 3'd0);
        push_exp(24'h200000, 24'h020000, 3'd1);
        run_seq("noloop", 10, 0, 32'h44, 32'h100, 32'hFE);
        check("noloop sb empty", 64'(sb_q.size()), 64'(0));

        // Looping sequence aborted by stop at cycle 10
        loop = 1'b1;
        push_exp(24'h100000, 24'h010000, 3'd0);
        push_exp(24'h200000, 24'h020000, 3'd1);
        push_exp(24'h100000, 24'h010000, 3'd0);
        run_seq("loop", 14, 10, 32'h244, 32'h0, 32'h7FE);
        check("loop stop carr hold", 64'(carr_freq), 64'(24'h100000));
        check("loop sb empty", 64'(sb_q.size()), 64'(0));

        // Dwell of zero behaves as one
        loop = 1'b0;
        last_idx = 3'd0;
        write_entry(3'd0, 24'h123456, 24'h000321, 16'd0);
        push_exp(24'h123456, 24'h000321, 3'd0);
        run_seq("dwell0", 5, 0, 32'h4, 32'h8, 32'h6);
        check("dwell0 sb empty", 64'(sb_q.size()), 64'(0));

        // Writes while busy are rejected and flagged
        write_entry(3'd0, 24'h100000, 24'h010000, 16'd3);
        push_exp(24'h100000, 24'h010000, 3'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("busy before we", 64'(busy), 64'(1));
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_carr = 24'hABCDEF; cfg_shift = 24'h111111; cfg_dwell = 16'd5;
        tick();
        cfg_we = 1'b0;
        check("busy we cfg_err", 64'(cfg_err), 64'(1));
        tick();
        check("cfg_err one cycle", 64'(cfg_err), 64'(0));
        for (int i = 0; i < 4; i++) tick();
        push_exp(24'h100000, 24'h010000, 3'd0);
        run_seq("rerun", 6, 0, 32'h4, 32'h20, 32'h1E);
        check("rerun sb empty", 64'(sb_q.size()), 64'(0));

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        check("start&stop busy c1", 64'(busy), 64'(0));
        tick();
        check("start&stop busy c2", 64'(busy), 64'(0));
        check("start&stop mod_en", 64'(mod_en), 64'(0));
        start = 1'b0;
        stop  = 1'b0;
        tick();

        // Reset mid-run clears outputs and the table
        push_exp(24'h100000, 24'h010000, 3'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-rst busy", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        check("midrst carr_freq", 64'(carr_freq), 64'(0));
        check("midrst freq_shift", 64'(freq_shift), 64'(0));
        check("midrst mod_en", 64'(mod_en), 64'(0));
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst cur_idx", 64'(cur_idx), 64'(0));
        check("midrst hop_stb", 64'(hop_stb), 64'(0));
        check("midrst done", 64'(done), 64'(0));
        rst = 1'b0;
        tick();
        check("midrst sb empty", 64'(sb_q.size()), 64'(0));
        last_idx = 3'd0;
        loop     = 1'b0;
        push_exp(24'h000000, 24'h000000, 3'd0);
        run_seq("cleared", 5, 0, 32'h4, 32'h8, 32'h6);
        check("cleared sb empty", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
